// File: rtl/board_mem.sv
// board_mem: multi-read-port board memory with a built-in clear engine.
// One write port (CPU stores) and NUM_RD registered read ports (CPU load, VGA, spare).
// After reset, and on clr_req, every word is swept to CLEAR_VALUE, one word per cycle.
//
// Ports:
//   clock    sole clock, rising edge
//   reset    asynchronous, active-high
//   wEn      write enable; honoured only when idle and wAddr < DEPTH
//   wAddr    write address
//   dataIn   write data
//   rAddr    packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   dataOut  packed registered read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rValid   per-port valid, set when the read was sampled while not busy
//   clr_req  one-cycle clear request, ignored while busy
//   busy     clear engine active
//   clr_done one-cycle pulse when a sweep completes
module board_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned READ_MODE  = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wEn,
    input  logic [ADDR_WIDTH-1:0]        wAddr,
    input  logic [DATA_WIDTH-1:0]        dataIn,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rAddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] dataOut,
    output logic [NUM_RD-1:0]            rValid,
    input  logic                         clr_req,
    output logic                         busy,
    output logic                         clr_done
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // ptr and range compares are one bit wider than an address so DEPTH == 2**ADDR_WIDTH fits.
    localparam logic [ADDR_WIDTH:0] DepthW  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LastPtr = DepthW - (ADDR_WIDTH+1)'(1);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH:0]     ptr_q, ptr_d;
    logic                    busy_q, busy_d;
    logic                    clr_done_q, clr_done_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    mem_we;
    logic [IdxW-1:0]         mem_idx;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    // Single array write port shared by the clear engine and the CPU.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        clr_done_d = 1'b0;
        mem_we     = 1'b0;
        mem_idx    = wAddr[IdxW-1:0];
        mem_wdata  = dataIn;
        case (state_q)
            StClear: begin
                mem_we    = 1'b1;
                mem_idx   = ptr_q[IdxW-1:0];
                mem_wdata = CLEAR_VALUE;
                if (ptr_q == LastPtr) begin
                    state_d    = StIdle;
                    busy_d     = 1'b0;
                    clr_done_d = 1'b1;
                    ptr_d      = '0;
                end else begin
                    ptr_d = ptr_q + (ADDR_WIDTH+1)'(1);
                end
            end
            StIdle: begin
                mem_we = wEn && ({1'b0, wAddr} < DepthW);
                if (clr_req) begin
                    state_d = StClear;
                    busy_d  = 1'b1;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                busy_d  = 1'b1;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StClear;
            ptr_q      <= '0;
            busy_q     <= 1'b1;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            clr_done_q <= clr_done_d;
        end
    end

    // Array has no reset; the clear engine initialises it.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    assign busy     = busy_q;
    assign clr_done = clr_done_q;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] raddr;
        logic [DATA_WIDTH-1:0] rd_q, rd_d;
        logic                  rvalid_q;

        assign raddr = rAddr[g*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd_d = '0;
            if ({1'b0, raddr} < DepthW) begin
                // Write-first bypass; read-first simply returns the old array word.
                if (READ_MODE == 1 && mem_we && mem_idx == raddr[IdxW-1:0]) begin
                    rd_d = mem_wdata;
                end else begin
                    rd_d = mem[raddr[IdxW-1:0]];
                end
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                rd_q     <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rd_q     <= rd_d;
                rvalid_q <= !busy_q;
            end
        end

        assign dataOut[g*DATA_WIDTH +: DATA_WIDTH] = rd_q;
        assign rValid[g]                           = rvalid_q;
    end

endmodule
